// File: rtl/set_mode_sequencer.sv
// Time-setting controller: Set presses walk RUN -> SET_HOUR -> SET_MIN -> RUN,
// Up presses (short or held auto-repeat) become single-cycle increment strobes,
// and an inactivity timeout falls back to RUN. All outputs are registered.
module set_mode_sequencer #(
    parameter int unsigned TIMEOUT_SEC   = 10,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tick_1Hz,
    input  logic       i_Tick_8Hz,
    input  logic       i_Set_Pulse,
    input  logic       i_Up_Level,
    input  logic       i_Up_Pulse,
    output logic       o_Increment,
    output logic       o_Reset_Sec,
    output logic [2:0] o_Enable_Count,
    output logic [1:0] o_Enable_Digits,
    output logic       o_Enable_Dot,
    output logic [1:0] o_Mode
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_SEC + 1);
    localparam int unsigned HoldW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned RepW  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

    localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_SEC);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] HoldFull = HoldW'(REPEAT_DELAY);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StIllegal = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             repeated_q, repeated_d;
    logic             up_level_q;

    logic             in_set, in_set_next, timeout, advance, up_rise, activity;
    logic             inc_d, reset_sec_d, dot_d;
    logic [2:0]       count_d;
    logic [1:0]       digits_d;

    assign in_set      = (state_q == StSetHour) || (state_q == StSetMin);
    assign in_set_next = (state_d == StSetHour) || (state_d == StSetMin);
    assign timeout     = in_set && (idle_q == IdleMax);
    assign up_rise     = i_Up_Level && !up_level_q;
    assign activity    = i_Set_Pulse || i_Up_Pulse || i_Up_Level;
    // Increments only happen when the mode is staying put this cycle.
    assign advance     = in_set && (state_d == state_q);

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: Set pulse advances the mode, timeout forces RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (i_Set_Pulse) state_d = StSetHour;
            StSetHour: begin
                if (i_Set_Pulse)  state_d = StSetMin;
                else if (timeout) state_d = StRun;
            end
            StSetMin:  if (i_Set_Pulse || timeout) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    // Idle timer, hold/auto-repeat counters and increment strobe decision
    always_comb begin
        idle_d     = idle_q;
        hold_d     = hold_q;
        rep_d      = rep_q;
        repeated_d = repeated_q;
        inc_d      = 1'b0;

        if (!in_set_next || activity) begin
            idle_d = '0;
        end else if (i_Tick_1Hz && (idle_q != IdleMax)) begin
            idle_d = idle_q + IdleW'(1);
        end

        if (!advance) begin
            hold_d     = '0;
            rep_d      = '0;
            repeated_d = 1'b0;
        end else begin
            // A release strobes only if the finished hold never auto-repeated.
            if (i_Up_Pulse && !repeated_q) inc_d = 1'b1;
            if (up_rise) begin
                hold_d     = '0;
                rep_d      = '0;
                repeated_d = 1'b0;
            end else if (i_Up_Level && i_Tick_8Hz) begin
                if (!repeated_q) begin
                    if (hold_q == HoldLast) begin
                        hold_d     = HoldFull;
                        rep_d      = '0;
                        repeated_d = 1'b1;
                        inc_d      = 1'b1;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end else if (rep_q == RepLast) begin
                    rep_d = '0;
                    inc_d = 1'b1;
                end else begin
                    rep_d = rep_q + RepW'(1);
                end
            end
        end
    end

    // Output decode from the upcoming state so outputs land with the transition
    always_comb begin
        count_d     = 3'b001;
        digits_d    = 2'b00;
        dot_d       = 1'b1;
        reset_sec_d = (state_q == StSetMin) && i_Set_Pulse;
        unique case (state_d)
            StSetHour: begin
                count_d  = 3'b100;
                digits_d = 2'b10;
                dot_d    = 1'b0;
            end
            StSetMin: begin
                count_d  = 3'b010;
                digits_d = 2'b01;
                dot_d    = 1'b0;
            end
            default: begin
                count_d  = 3'b001;
                digits_d = 2'b00;
                dot_d    = 1'b1;
            end
        endcase
    end

    // Counter and registered-output state
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            idle_q          <= '0;
            hold_q          <= '0;
            rep_q           <= '0;
            repeated_q      <= 1'b0;
            up_level_q      <= 1'b0;
            o_Increment     <= 1'b0;
            o_Reset_Sec     <= 1'b0;
            o_Enable_Count  <= 3'b001;
            o_Enable_Digits <= 2'b00;
            o_Enable_Dot    <= 1'b1;
        end else begin
            idle_q          <= idle_d;
            hold_q          <= hold_d;
            rep_q           <= rep_d;
            repeated_q      <= repeated_d;
            up_level_q      <= i_Up_Level;
            o_Increment     <= inc_d;
            o_Reset_Sec     <= reset_sec_d;
            o_Enable_Count  <= count_d;
            o_Enable_Digits <= digits_d;
            o_Enable_Dot    <= dot_d;
        end
    end

    assign o_Mode = state_q;

endmodule

// File: tb/tb_set_mode_sequencer.sv
// Self-checking bench for set_mode_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_set_mode_sequencer;

    localparam int TIMEOUT_SEC   = 10;
    localparam int REPEAT_DELAY  = 8;
    localparam int REPEAT_PERIOD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick1 = 1'b0, tick8 = 1'b0, set_p = 1'b0, up_lvl = 1'b0, up_p = 1'b0;
    logic       inc, rsec, dot;
    logic [2:0] en_count;
    logic [1:0] en_digits, mode;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_mode = 0;
    int m_idle = 0;
    int m_hold = 0;
    bit m_prev_lvl = 0;
    bit m_inc = 0;
    bit m_rsec = 0;

    // Observed strobe tallies for scenario-level checks
    int inc_seen = 0;
    int rsec_seen = 0;

    set_mode_sequencer #(
        .TIMEOUT_SEC  (TIMEOUT_SEC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Tick_1Hz     (tick1),
        .i_Tick_8Hz     (tick8),
        .i_Set_Pulse    (set_p),
        .i_Up_Level     (up_lvl),
        .i_Up_Pulse     (up_p),
        .o_Increment    (inc),
        .o_Reset_Sec    (rsec),
        .o_Enable_Count (en_count),
        .o_Enable_Digits(en_digits),
        .o_Enable_Dot   (dot),
        .o_Mode         (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_count(input int md);
        return (md == 1) ? 3'b100 : (md == 2) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [1:0] exp_digits(input int md);
        return (md == 1) ? 2'b10 : (md == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idle = 0; m_hold = 0; m_prev_lvl = 0; m_inc = 0; m_rsec = 0;
    endtask

    // One clock of the behavioural rules, applied to the inputs seen at the edge
    task automatic model_step();
        bit in_set, tmo, rise;
        int nxt;
        in_set = (m_mode != 0);
        tmo    = in_set && (m_idle == TIMEOUT_SEC);
        nxt    = m_mode;
        if (set_p)    nxt = (m_mode + 1) % 3;
        else if (tmo) nxt = 0;
        rise   = up_lvl && !m_prev_lvl;
        m_inc  = 0;
        m_rsec = set_p && (m_mode == 2);
        if (in_set && nxt == m_mode) begin
            // A hold counts as repeated once it has reached the delay.
            if (up_p && m_hold < REPEAT_DELAY) m_inc = 1;
            if (rise) m_hold = 0;
            else if (up_lvl && tick8) begin
                m_hold++;
                if (m_hold >= REPEAT_DELAY && (m_hold - REPEAT_DELAY) % REPEAT_PERIOD == 0)
                    m_inc = 1;
            end
        end else begin
            m_hold = 0;
        end
        if (nxt == 0 || set_p || up_p || up_lvl) m_idle = 0;
        else if (tick1) m_idle++;
        m_prev_lvl = up_lvl;
        m_mode = nxt;
    endtask

    // Apply current inputs across one edge, check every output, clear pulses
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("inc", {31'd0, inc}, {31'd0, m_inc});
        check("reset_sec", {31'd0, rsec}, {31'd0, m_rsec});
        check("mode", {30'd0, mode}, m_mode);
        check("en_count", {29'd0, en_count}, {29'd0, exp_count(m_mode)});
        check("en_digits", {30'd0, en_digits}, {30'd0, exp_digits(m_mode)});
        check("en_dot", {31'd0, dot}, {31'd0, m_mode == 0});
        inc_seen  += int'(inc);
        rsec_seen += int'(rsec);
        tick1 = 0; tick8 = 0; set_p = 0; up_p = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_set();
        set_p = 1; cycle();
    endtask

    task automatic tick8_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick8 = 1; cycle(); idle_cycles(2);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must respond at once
    task automatic async_reset(input string tag);
        rst_n = 0;
        #1;
        check({tag, "_count"}, {29'd0, en_count}, 32'h1);
        check({tag, "_digits"}, {30'd0, en_digits}, 32'h0);
        check({tag, "_dot"}, {31'd0, dot}, 32'h1);
        check({tag, "_mode"}, {30'd0, mode}, 32'h0);
        check({tag, "_strobes"}, {30'd0, inc, rsec}, 32'h0);
        model_reset();
        #2;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        #12;
        async_reset("por");
        idle_cycles(3);

        // Three Set pulses: 01, 10, 00 with a single seconds clear on the last
        rsec_seen = 0;
        pulse_set();
        check("walk_hour", {30'd0, mode}, 32'h1);
        pulse_set();
        check("walk_min", {30'd0, mode}, 32'h2);
        check("walk_rsec_early", rsec_seen, 0);
        pulse_set();
        check("walk_run", {30'd0, mode}, 32'h0);
        idle_cycles(2);
        check("walk_rsec", rsec_seen, 1);

        // SET_HOUR short hold: one increment, delivered by the release pulse
        pulse_set();
        inc_seen = 0;
        up_lvl = 1; idle_cycles(2);
        tick8_n(4);
        up_lvl = 0; up_p = 1; cycle();
        idle_cycles(3);
        check("short_hold", inc_seen, 1);

        // SET_MIN long hold: strobes at ticks 8, 10, 12, 14 and none on release
        pulse_set();
        inc_seen = 0;
        up_lvl = 1; idle_cycles(2);
        tick8_n(14);
        check("long_hold", inc_seen, 4);
        up_lvl = 0; up_p = 1; cycle();
        idle_cycles(3);
        check("long_release", inc_seen, 4);

        // Timeout from SET_HOUR returns to RUN without clearing seconds
        pulse_set();
        pulse_set();
        check("to_start", {30'd0, mode}, 32'h1);
        rsec_seen = 0;
        for (int i = 0; i < TIMEOUT_SEC; i++) begin
            tick1 = 1; cycle(); idle_cycles(3);
        end
        idle_cycles(2);
        check("timeout_mode", {30'd0, mode}, 32'h0);
        check("timeout_rsec", rsec_seen, 0);
        inc_seen = 0;
        up_p = 1; cycle();
        idle_cycles(2);
        check("run_up_pulse", inc_seen, 0);

        // Set and Up pulse together in SET_HOUR: mode advances, increment dropped
        pulse_set();
        inc_seen = 0;
        set_p = 1; up_p = 1; cycle();
        idle_cycles(2);
        check("set_wins_mode", {30'd0, mode}, 32'h2);
        check("set_wins_inc", inc_seen, 0);

        // Reset during an auto-repeat in SET_MIN
        up_lvl = 1; idle_cycles(1);
        tick8_n(9);
        async_reset("mid_reset");
        up_lvl = 0;
        idle_cycles(3);

        // Randomized traffic
        for (int n = 0; n < 6000; n++) begin
            tick1 = ($urandom_range(0, 4) == 0);
            tick8 = ($urandom_range(0, 2) == 0);
            set_p = ($urandom_range(0, 59) == 0);
            if (up_lvl) begin
                if ($urandom_range(0, 29) == 0) begin
                    up_lvl = 0; up_p = 1;
                end
            end else if ($urandom_range(0, 79) == 0) begin
                up_lvl = 1;
            end
            if ($urandom_range(0, 299) == 0) up_p = 1;
            if ($urandom_range(0, 1999) == 0) begin
                async_reset("rand_reset");
                tick1 = 0; tick8 = 0; set_p = 0; up_p = 0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
